fsm_sync_tx: RTL and testbench

//   Bit-serial frame transmitter for the "101" sequence-detector link. Emits a
//   3-bit sync word (1,0,1), then a DATA_W-bit payload MSB-first, then GAP_CYCLES idle zeros.

---
 rtl/fsm_sync_pkg.sv | 24 ++
 rtl/fsm_sync_piso.sv | 27 ++
 rtl/fsm_sync_tx.sv | 155 +++++++++++++++
 tb/tb_fsm_sync_tx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fsm_sync_pkg.sv
// Shared types and constants for the "101"-sync serial frame transmitter.
package fsm_sync_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    PAR,
    GAP
  } state_e;

  localparam logic [2:0] SYNC_WORD = 3'b101;
  localparam int         SYNC_LEN  = 3;

  // Width of a counter that must reach the longest per-state run length.
  function automatic int cnt_width(input int data_w, input int gap_cycles);
    int longest;
    longest = SYNC_LEN;
    if (data_w > longest) longest = data_w;
    if (gap_cycles > longest) longest = gap_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/fsm_sync_piso.sv
// Parallel-load, MSB-first shift register feeding the payload phase of a frame.
module fsm_sync_piso #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              msb_o
);

  logic [DATA_W-1:0] shreg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
    end else if (shift_i) begin
      shreg_q <= shreg_q << 1;
    end
  end

  assign msb_o = shreg_q[DATA_W-1];

endmodule

// File: rtl/fsm_sync_tx.sv
// Bit-serial frame transmitter: sync word 1,0,1, MSB-first payload, idle gap.
// Optional even-parity bit after the payload when FSM_SYNC_TX_PARITY_EN is defined.
module fsm_sync_tx
  import fsm_sync_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              out,
  output logic              busy,
  output logic              done
);

  localparam int            CW        = cnt_width(DATA_W, GAP_CYCLES);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load, shift, msb;
  logic          to_tail;
  logic [1:0]    sync_idx;

  fsm_sync_piso #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (data),
    .msb_o   (msb)
  );

`ifdef FSM_SYNC_TX_PARITY_EN
  logic parity_q;

  // Parity is taken from the accepted word, so later data changes cannot leak in.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are computed for the bit the next state will present, so they land registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    out_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    to_tail  = 1'b0;
    sync_idx = 2'(SYNC_LEN - 2) - cnt_q[1:0];

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          load    = 1'b1;
          state_d = SYNC;
          out_d   = SYNC_WORD[SYNC_LEN-1];
          busy_d  = 1'b1;
        end
      end
      SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          out_d   = msb;
          shift   = 1'b1;
        end else begin
          out_d = SYNC_WORD[sync_idx];
        end
      end
      DATA: begin
        if (cnt_q == DATA_LAST) begin
`ifdef FSM_SYNC_TX_PARITY_EN
          state_d = PAR;
          cnt_d   = '0;
          out_d   = parity_q;
`else
          to_tail = 1'b1;
`endif
        end else begin
          out_d = msb;
          shift = 1'b1;
        end
      end
`ifdef FSM_SYNC_TX_PARITY_EN
      PAR: begin
        to_tail = 1'b1;
      end
`endif
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Leaving the payload (or parity) phase: idle gap, or straight home when there is none.
    if (to_tail) begin
      cnt_d = '0;
      if (GAP_CYCLES == 0) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = GAP;
      end
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_fsm_sync_tx.sv
// Self-checking bench for fsm_sync_tx (DATA_W=8, GAP_CYCLES=2): vector table plus corner sequences.
module tb_fsm_sync_tx;

`ifdef FSM_SYNC_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = 3 + 8 + P + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       out, busy, done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic       st;
    logic [7:0] d;
    logic [2:0] exp;   // {out, busy, done} after the edge
  } vec_t;

  vec_t vq[$];

  fsm_sync_tx #(
    .DATA_W     (8),
    .GAP_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic void push(input logic rst, input logic st, input logic [7:0] d,
                               input logic [2:0] exp);
    vec_t v;
    v.rst = rst;
    v.st  = st;
    v.d   = d;
    v.exp = exp;
    vq.push_back(v);
  endfunction

  // mode 0: single start pulse; 1: start held high; 2: extra start pulse mid-frame.
  // Data is inverted after the accept edge to show the captured word is used.
  function automatic void push_frame(input logic [7:0] d, input int mode);
    logic b;
    logic st;
    push(1'b0, 1'b1, d, 3'b110);
    for (int i = 1; i < FL; i++) begin
      if (i == 1) b = 1'b0;
      else if (i == 2) b = 1'b1;
      else if (i < 11) b = d[10-i];
      else if (P == 1 && i == 11) b = ^d;
      else b = 1'b0;
      st = (mode == 1) || (mode == 2 && i == 5);
      push(1'b0, st, ~d, {b, 1'b1, 1'b0});
    end
    push(1'b0, mode == 1, ~d, 3'b001);
  endfunction

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {out,busy,done}=%b, expected %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial begin
    logic [2:0] hist;
    int         det_cnt;
    int         det_idx;

    // Reset (dominating start), then a quiet idle line.
    push(1'b1, 1'b1, 8'hA5, 3'b000);
    push(1'b1, 1'b1, 8'hA5, 3'b000);
    for (int i = 0; i < 10; i++) push(1'b0, 1'b0, 8'h00, 3'b000);
    // Reference frame with an ignored mid-frame start.
    push_frame(8'hA5, 2);
    push(1'b0, 1'b0, 8'h00, 3'b000);
    // Start held high: three back-to-back frames, then release.
    push_frame(8'hFF, 1);
    push_frame(8'hFF, 1);
    push_frame(8'hFF, 1);
    push(1'b0, 1'b0, 8'hFF, 3'b000);
    push_frame(8'h01, 0);
    push_frame(8'h80, 0);
    push_frame(8'h07, 0);
    push(1'b0, 1'b0, 8'h00, 3'b000);
    // Reset during the payload (data C3 = 1100_0011): frame aborted, no done.
    push(1'b0, 1'b1, 8'hC3, 3'b110);
    push(1'b0, 1'b0, 8'hC3, 3'b010);
    push(1'b0, 1'b0, 8'hC3, 3'b110);
    push(1'b0, 1'b0, 8'hC3, 3'b110);
    push(1'b0, 1'b0, 8'hC3, 3'b110);
    push(1'b1, 1'b0, 8'hC3, 3'b000);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 8'hC3, 3'b000);
    push_frame(8'hC3, 0);
    push(1'b0, 1'b0, 8'h00, 3'b000);

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst;
      start = vq[i].st;
      data  = vq[i].d;
      @(posedge clk);
      #1;
      check($sformatf("row %0d", i), {out, busy, done}, vq[i].exp);
    end

    // Loopback into a 101 detector: an all-zero payload yields exactly one hit,
    // reported in the cycle after the third sync bit.
    hist    = 3'b000;
    det_cnt = 0;
    det_idx = -1;
    for (int i = 0; i < FL + 3; i++) begin
      reset = 1'b0;
      start = (i == 0);
      data  = 8'h00;
      @(posedge clk);
      #1;
      if (hist == 3'b101) begin
        det_cnt++;
        if (det_idx < 0) det_idx = i;
      end
      hist = {hist[1:0], out};
    end
    check_int("loopback detect count", det_cnt, 1);
    check_int("loopback detect cycle", det_idx, 3);
    check("loopback idle after frame", {out, busy, done}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
